// File: rtl/punc_pkg.sv
// Shared encodings for the punc datapath: mux select codes and memory FSM states.
package punc_pkg;

  localparam logic [1:0] PC_SEL_OFF9  = 2'd0;
  localparam logic [1:0] PC_SEL_OFF11 = 2'd1;
  localparam logic [1:0] PC_SEL_RQ    = 2'd2;

  localparam logic [1:0] WD_SEL_ALU = 2'd0;
  localparam logic [1:0] WD_SEL_MDR = 2'd1;
  localparam logic [1:0] WD_SEL_PC  = 2'd2;
  localparam logic [1:0] WD_SEL_MUL = 2'd3;

  localparam logic [1:0] ALU_PASS_A = 2'd0;
  localparam logic [1:0] ALU_ADD    = 2'd1;
  localparam logic [1:0] ALU_AND    = 2'd2;
  localparam logic [1:0] ALU_NOT    = 2'd3;

  localparam logic [1:0] MA_SEL_PC      = 2'd0;
  localparam logic [1:0] MA_SEL_PC_OFF9 = 2'd1;
  localparam logic [1:0] MA_SEL_RP      = 2'd2;
  localparam logic [1:0] MA_SEL_RQ_OFF6 = 2'd3;

  typedef logic [1:0] mem_state_t;
  localparam mem_state_t MEM_IDLE   = 2'd0;
  localparam mem_state_t MEM_REQ    = 2'd1;
  localparam mem_state_t MEM_WAIT_R = 2'd2;

endpackage

// File: rtl/punc_mul_seq.sv
// Radix-2 shift-add multiplier: busy for exactly WIDTH cycles, result held until the next start.
module punc_mul_seq
  import punc_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] accSum;

  // The result register only updates on the final iteration, so a read during busy sees the old product.
  always_comb begin
    count_d  = count_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    result_d = result_q;
    accSum   = acc_q + (mplier_q[0] ? mcand_q : '0);
    if (count_q == '0) begin
      if (start) begin
        mcand_d  = a;
        mplier_d = b;
        acc_d    = '0;
        count_d  = CW'(WIDTH);
      end
    end else begin
      acc_d    = accSum;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      count_d  = count_q - CW'(1);
      if (count_q == CW'(1)) result_d = accSum;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      count_q  <= count_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  assign busy   = (count_q != '0);
  assign result = result_q;

endmodule

// File: rtl/punc_datapath_v2.sv
// Punc CPU datapath: PC/IR/MDR, register file, ALU, condition codes, memory request FSM
// and a concurrent sequential multiplier.
module punc_datapath_v2
  import punc_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NREG  = 8,
  localparam int RAW  = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pc_ld,
  input  logic             pc_inc,
  input  logic [1:0]       pc_sel,
  input  logic             ir_ld,
  input  logic             rf_w_wr,
  input  logic             rf_w_addr_sel,
  input  logic [1:0]       rf_w_data_sel,
  input  logic             rf_rp_addr_sel,
  input  logic [1:0]       alu_sel,
  input  logic             alu_in_a_sel,
  input  logic             nzp_ld,
  input  logic             mul_start,
  input  logic             mem_rd,
  input  logic             mem_wr,
  input  logic [1:0]       mem_addr_sel,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic [WIDTH-1:0] mem_addr_o,
  output logic [WIDTH-1:0] mem_wdata_o,
  input  logic             mem_ready_i,
  input  logic             mem_rvalid_i,
  input  logic [WIDTH-1:0] mem_rdata_i,
  output logic             mem_busy,
  output logic             mul_busy,
  output logic             nzp_match,
  output logic [WIDTH-1:0] ir_out,
  output logic [WIDTH-1:0] pc_debug_data,
  input  logic [RAW-1:0]   rf_debug_addr,
  output logic [WIDTH-1:0] rf_debug_data
);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] ir_q, ir_d;
  logic [WIDTH-1:0] mdr_q, mdr_d;
  logic             n_q, z_q, p_q, n_d, z_d, p_d;
  mem_state_t       memState_q, memState_d;
  logic [WIDTH-1:0] memAddr_q, memAddr_d;
  logic [WIDTH-1:0] memWdata_q, memWdata_d;
  logic             memWe_q, memWe_d;
  logic [WIDTH-1:0] rf_q [NREG];

  logic [WIDTH-1:0] sext11, sext9, sext6, sext5;
  logic [RAW-1:0]   rpAddr, rqAddr, wAddr;
  logic [WIDTH-1:0] rpData, rqData, aluA, aluOut, wData, pcTarget, memAddrMux, mulResult;

  assign sext11 = {{(WIDTH-11){ir_q[10]}}, ir_q[10:0]};
  assign sext9  = {{(WIDTH-9){ir_q[8]}}, ir_q[8:0]};
  assign sext6  = {{(WIDTH-6){ir_q[5]}}, ir_q[5:0]};
  assign sext5  = {{(WIDTH-5){ir_q[4]}}, ir_q[4:0]};

  // Register fields are 3 bits wide in the IR; larger files reach upper registers only via the link path.
  assign rpAddr = rf_rp_addr_sel ? RAW'(ir_q[2:0]) : RAW'(ir_q[11:9]);
  assign rqAddr = RAW'(ir_q[8:6]);
  assign wAddr  = rf_w_addr_sel ? RAW'(NREG - 1) : RAW'(ir_q[11:9]);

  assign rpData        = rf_q[rpAddr];
  assign rqData        = rf_q[rqAddr];
  assign rf_debug_data = rf_q[rf_debug_addr];

  always_comb begin
    aluA = alu_in_a_sel ? sext5 : rpData;
    case (alu_sel)
      ALU_PASS_A: aluOut = aluA;
      ALU_ADD:    aluOut = rqData + aluA;
      ALU_AND:    aluOut = rqData & aluA;
      default:    aluOut = ~rqData;
    endcase
    case (rf_w_data_sel)
      WD_SEL_ALU: wData = aluOut;
      WD_SEL_MDR: wData = mdr_q;
      WD_SEL_PC:  wData = pc_q;
      default:    wData = mulResult;
    endcase
    case (pc_sel)
      PC_SEL_OFF9:  pcTarget = pc_q + sext9;
      PC_SEL_OFF11: pcTarget = pc_q + sext11;
      default:      pcTarget = rqData;
    endcase
    case (mem_addr_sel)
      MA_SEL_PC:      memAddrMux = pc_q;
      MA_SEL_PC_OFF9: memAddrMux = pc_q + sext9;
      MA_SEL_RP:      memAddrMux = rpData;
      default:        memAddrMux = rqData + sext6;
    endcase
  end

  // Architectural registers: increment wins over load, condition codes follow the RF write data.
  always_comb begin
    pc_d = pc_q;
    if (pc_inc)     pc_d = pc_q + WIDTH'(1);
    else if (pc_ld) pc_d = pcTarget;
    ir_d = ir_ld ? mdr_q : ir_q;
    n_d  = n_q;
    z_d  = z_q;
    p_d  = p_q;
    if (nzp_ld) begin
      n_d = wData[WIDTH-1];
      z_d = (wData == '0);
      p_d = ~wData[WIDTH-1] & (wData != '0);
    end
  end

  // Request FSM: address, data and direction are captured once and held until the memory accepts.
  always_comb begin
    memState_d = memState_q;
    memAddr_d  = memAddr_q;
    memWdata_d = memWdata_q;
    memWe_d    = memWe_q;
    mdr_d      = mdr_q;
    case (memState_q)
      MEM_IDLE: begin
        if (mem_rd || mem_wr) begin
          memAddr_d  = memAddrMux;
          memWdata_d = rpData;
          memWe_d    = mem_wr;
          memState_d = MEM_REQ;
        end
      end
      MEM_REQ: begin
        if (mem_ready_i) memState_d = memWe_q ? MEM_IDLE : MEM_WAIT_R;
      end
      MEM_WAIT_R: begin
        if (mem_rvalid_i) begin
          mdr_d      = mem_rdata_i;
          memState_d = MEM_IDLE;
        end
      end
      default: memState_d = MEM_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= '0;
      ir_q       <= '0;
      mdr_q      <= '0;
      n_q        <= 1'b0;
      z_q        <= 1'b0;
      p_q        <= 1'b0;
      memState_q <= MEM_IDLE;
      memAddr_q  <= '0;
      memWdata_q <= '0;
      memWe_q    <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      mdr_q      <= mdr_d;
      n_q        <= n_d;
      z_q        <= z_d;
      p_q        <= p_d;
      memState_q <= memState_d;
      memAddr_q  <= memAddr_d;
      memWdata_q <= memWdata_d;
      memWe_q    <= memWe_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (rf_w_wr) begin
      rf_q[wAddr] <= wData;
    end
  end

  punc_mul_seq #(.WIDTH(WIDTH)) uMul (
    .clk    (clk),
    .rst    (rst),
    .start  (mul_start),
    .a      (rqData),
    .b      (rpData),
    .busy   (mul_busy),
    .result (mulResult)
  );

  assign mem_req_o     = (memState_q == MEM_REQ);
  assign mem_busy      = (memState_q != MEM_IDLE);
  assign mem_we_o      = memWe_q;
  assign mem_addr_o    = memAddr_q;
  assign mem_wdata_o   = memWdata_q;
  assign nzp_match     = (ir_q[11] & n_q) | (ir_q[10] & z_q) | (ir_q[9] & p_q) | (ir_q[11:9] == 3'b000);
  assign ir_out        = ir_q;
  assign pc_debug_data = pc_q;

endmodule

// File: tb/tb_punc_datapath_v2.sv
// Directed bench: a 16-bit/8-register and a 32-bit/16-register datapath share one control stream.
module tb_punc_datapath_v2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, pcLd, pcInc, irLd, rfWWr, rfWAddrSel, rfRpAddrSel, aluInASel, nzpLd, mulStart;
  logic        memRd, memWr, memReady, memRvalid;
  logic [1:0]  pcSel, rfWDataSel, aluSel, memAddrSel;
  logic [15:0] memRdata;
  logic [2:0]  dbgAddrN;
  logic [3:0]  dbgAddrW;

  logic        memReqN, memWeN, memBusyN, mulBusyN, nzpMatchN;
  logic [15:0] memAddrN, memWdataN, irN, pcN, rfDataN;
  logic        memReqW, memWeW, memBusyW, mulBusyW, nzpMatchW;
  logic [31:0] memAddrW, memWdataW, irW, pcW, rfDataW;

  int checkCount = 0;
  int errorCount = 0;
  int nBusy, wBusy;

  punc_datapath_v2 #(.WIDTH(16), .NREG(8)) dutN (
    .clk(clk), .rst(rst), .pc_ld(pcLd), .pc_inc(pcInc), .pc_sel(pcSel), .ir_ld(irLd),
    .rf_w_wr(rfWWr), .rf_w_addr_sel(rfWAddrSel), .rf_w_data_sel(rfWDataSel),
    .rf_rp_addr_sel(rfRpAddrSel), .alu_sel(aluSel), .alu_in_a_sel(aluInASel), .nzp_ld(nzpLd),
    .mul_start(mulStart), .mem_rd(memRd), .mem_wr(memWr), .mem_addr_sel(memAddrSel),
    .mem_req_o(memReqN), .mem_we_o(memWeN), .mem_addr_o(memAddrN), .mem_wdata_o(memWdataN),
    .mem_ready_i(memReady), .mem_rvalid_i(memRvalid), .mem_rdata_i(memRdata),
    .mem_busy(memBusyN), .mul_busy(mulBusyN), .nzp_match(nzpMatchN), .ir_out(irN),
    .pc_debug_data(pcN), .rf_debug_addr(dbgAddrN), .rf_debug_data(rfDataN)
  );

  punc_datapath_v2 #(.WIDTH(32), .NREG(16)) dutW (
    .clk(clk), .rst(rst), .pc_ld(pcLd), .pc_inc(pcInc), .pc_sel(pcSel), .ir_ld(irLd),
    .rf_w_wr(rfWWr), .rf_w_addr_sel(rfWAddrSel), .rf_w_data_sel(rfWDataSel),
    .rf_rp_addr_sel(rfRpAddrSel), .alu_sel(aluSel), .alu_in_a_sel(aluInASel), .nzp_ld(nzpLd),
    .mul_start(mulStart), .mem_rd(memRd), .mem_wr(memWr), .mem_addr_sel(memAddrSel),
    .mem_req_o(memReqW), .mem_we_o(memWeW), .mem_addr_o(memAddrW), .mem_wdata_o(memWdataW),
    .mem_ready_i(memReady), .mem_rvalid_i(memRvalid), .mem_rdata_i({16'h0000, memRdata}),
    .mem_busy(memBusyW), .mul_busy(mulBusyW), .nzp_match(nzpMatchW), .ir_out(irW),
    .pc_debug_data(pcW), .rf_debug_addr(dbgAddrW), .rf_debug_data(rfDataW)
  );

  // Every comparison in the bench funnels through here so the counters stay honest.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Inputs change 1 time unit after a rising edge and are sampled by the next one.
  task automatic applyStimulus();
    tick();
  endtask

  task automatic loadIr(input logic [15:0] value);
    memAddrSel = 2'd0;
    memRd = 1'b1;
    applyStimulus();
    memRd = 1'b0;
    memReady = 1'b1;
    applyStimulus();
    memReady = 1'b0;
    memRvalid = 1'b1;
    memRdata = value;
    applyStimulus();
    memRvalid = 1'b0;
    irLd = 1'b1;
    applyStimulus();
    irLd = 1'b0;
  endtask

  task automatic aluWrite(input logic [1:0] op, input logic aSel, input logic rpSel);
    rfWWr = 1'b1; rfWDataSel = 2'd0; rfWAddrSel = 1'b0; nzpLd = 1'b1;
    aluSel = op; aluInASel = aSel; rfRpAddrSel = rpSel;
    applyStimulus();
    rfWWr = 1'b0; nzpLd = 1'b0;
  endtask

  task automatic mulWriteBack(input logic link);
    rfWWr = 1'b1; rfWDataSel = 2'd3; rfWAddrSel = link; nzpLd = 1'b1;
    applyStimulus();
    rfWWr = 1'b0; nzpLd = 1'b0; rfWAddrSel = 1'b0;
  endtask

  task automatic runMul(output int narrowCycles, output int wideCycles);
    rfRpAddrSel = 1'b1;
    mulStart = 1'b1;
    applyStimulus();
    mulStart = 1'b0;
    narrowCycles = 0;
    wideCycles = 0;
    for (int i = 0; i < 100; i++) begin
      if (!mulBusyN && !mulBusyW) break;
      if (mulBusyN) narrowCycles++;
      if (mulBusyW) wideCycles++;
      applyStimulus();
    end
  endtask

  task automatic readRegs(input int idx);
    dbgAddrN = 3'(idx);
    dbgAddrW = 4'(idx);
    #1;
  endtask

  initial begin
    rst = 1'b1; pcLd = 0; pcInc = 0; irLd = 0; rfWWr = 0; rfWAddrSel = 0; rfRpAddrSel = 0;
    aluInASel = 0; nzpLd = 0; mulStart = 0; memRd = 0; memWr = 0; memReady = 0; memRvalid = 0;
    pcSel = 0; rfWDataSel = 0; aluSel = 0; memAddrSel = 0; memRdata = 16'h0000;
    dbgAddrN = 0; dbgAddrW = 0;
    applyStimulus();
    applyStimulus();
    rst = 1'b0;
    applyStimulus();

    checkOutput("reset_pc", pcN, 16'h0000);
    checkOutput("reset_ir", irN, 16'h0000);
    checkOutput("reset_req", memReqN, 1'b0);
    checkOutput("reset_we", memWeN, 1'b0);
    checkOutput("reset_addr", memAddrN, 16'h0000);
    checkOutput("reset_wdata", memWdataN, 16'h0000);
    checkOutput("reset_busy", {memBusyN, mulBusyN}, 2'b00);

    // Branch with all condition codes clear after reset.
    loadIr(16'h0E00);
    checkOutput("ir_load", irN, 16'h0E00);
    checkOutput("br_nzp000", nzpMatchN, 1'b0);

    // PC = 0 + sext(0x010), then a read whose acceptance is stalled two cycles.
    loadIr(16'h0010);
    pcLd = 1'b1; pcSel = 2'd0;
    applyStimulus();
    pcLd = 1'b0;
    checkOutput("pc_off9", pcN, 16'h0010);
    memAddrSel = 2'd0; memRd = 1'b1;
    applyStimulus();
    memRd = 1'b0;
    checkOutput("rd_req", {memReqN, memWeN, memBusyN}, 3'b101);
    checkOutput("rd_addr", memAddrN, 16'h0010);
    for (int i = 0; i < 2; i++) begin
      memRd = 1'b1; memAddrSel = 2'd2;
      applyStimulus();
      memRd = 1'b0; memAddrSel = 2'd0;
      checkOutput("rd_stall_req", memReqN, 1'b1);
      checkOutput("rd_stall_addr", memAddrN, 16'h0010);
    end
    memReady = 1'b1;
    applyStimulus();
    memReady = 1'b0;
    checkOutput("rd_wait", {memReqN, memBusyN}, 2'b01);
    memRvalid = 1'b1; memRdata = 16'hBEEF;
    applyStimulus();
    memRvalid = 1'b0;
    checkOutput("rd_done_busy", memBusyN, 1'b0);
    applyStimulus();
    checkOutput("no_second_req", {memReqN, memBusyN}, 2'b00);
    irLd = 1'b1;
    applyStimulus();
    irLd = 1'b0;
    checkOutput("mdr_rdata", irN, 16'hBEEF);
    memRvalid = 1'b1; memRdata = 16'h1111;
    applyStimulus();
    memRvalid = 1'b0;
    irLd = 1'b1;
    applyStimulus();
    irLd = 1'b0;
    checkOutput("stray_rvalid", irN, 16'hBEEF);

    // R1 = 3, R2 = 5, R3 = R1 * R2.
    loadIr(16'h1223);
    aluWrite(2'd1, 1'b1, 1'b0);
    loadIr(16'h1425);
    aluWrite(2'd1, 1'b1, 1'b0);
    readRegs(1);
    checkOutput("add_r1", rfDataN, 16'h0003);
    readRegs(2);
    checkOutput("add_r2", rfDataN, 16'h0005);
    loadIr(16'h0642);
    runMul(nBusy, wBusy);
    checkOutput("mul16_busy", nBusy, 16);
    checkOutput("mul16_busy_w", wBusy, 32);
    mulWriteBack(1'b0);
    readRegs(3);
    checkOutput("mul_r3", rfDataN, 16'h000F);
    checkOutput("mul_r3_w", rfDataW, 32'h0000000F);
    loadIr(16'h0200);
    checkOutput("nzp_p", nzpMatchN, 1'b1);
    loadIr(16'h0800);
    checkOutput("nzp_n_clear", nzpMatchN, 1'b0);
    loadIr(16'h0400);
    checkOutput("nzp_z_clear", nzpMatchN, 1'b0);

    // Pass-immediate, AND and NOT through the ALU.
    loadIr(16'h0C2A);
    aluWrite(2'd0, 1'b1, 1'b0);
    readRegs(6);
    checkOutput("alu_pass", rfDataN, 16'h000A);
    loadIr(16'h08C2);
    aluWrite(2'd2, 1'b0, 1'b1);
    readRegs(4);
    checkOutput("alu_and", rfDataN, 16'h0005);
    loadIr(16'h0AC0);
    aluWrite(2'd3, 1'b0, 1'b0);
    readRegs(5);
    checkOutput("alu_not", rfDataN, 16'hFFF0);
    checkOutput("alu_not_w", rfDataW, 32'hFFFFFFF0);
    loadIr(16'h0800);
    checkOutput("nzp_n", nzpMatchN, 1'b1);
    loadIr(16'h0200);
    checkOutput("nzp_p_clear", nzpMatchN, 1'b0);

    // Simultaneous read and write requests resolve to a write of R2 to address R2.
    loadIr(16'h0400);
    memRd = 1'b1; memWr = 1'b1; memAddrSel = 2'd2; rfRpAddrSel = 1'b0;
    applyStimulus();
    memRd = 1'b0; memWr = 1'b0; memAddrSel = 2'd0;
    checkOutput("wr_req_we", {memReqN, memWeN}, 2'b11);
    checkOutput("wr_addr", memAddrN, 16'h0005);
    checkOutput("wr_wdata", memWdataN, 16'h0005);
    memReady = 1'b1;
    applyStimulus();
    memReady = 1'b0;
    checkOutput("wr_done", {memReqN, memBusyN}, 2'b00);

    // All-ones times two into the link register.
    loadIr(16'h123F);
    aluWrite(2'd1, 1'b1, 1'b0);
    readRegs(1);
    checkOutput("r1_ones", rfDataN, 16'hFFFF);
    checkOutput("r1_ones_w", rfDataW, 32'hFFFFFFFF);
    loadIr(16'h1422);
    aluWrite(2'd1, 1'b1, 1'b0);
    loadIr(16'h0642);
    runMul(nBusy, wBusy);
    checkOutput("mul32_busy", wBusy, 32);
    mulWriteBack(1'b1);
    readRegs(7);
    checkOutput("link_r7", rfDataN, 16'hFFFE);
    readRegs(15);
    checkOutput("link_r15_w", rfDataW, 32'hFFFFFFFE);

    // PC = 0x0010 + sext(0x7EF) = all ones, then increment beats load.
    loadIr(16'h07EF);
    pcLd = 1'b1; pcSel = 2'd1;
    applyStimulus();
    checkOutput("pc_off11", pcN, 16'hFFFF);
    checkOutput("pc_off11_w", pcW, 32'hFFFFFFFF);
    pcInc = 1'b1;
    applyStimulus();
    pcInc = 1'b0; pcLd = 1'b0; pcSel = 2'd0;
    checkOutput("pc_wrap", pcN, 16'h0000);
    checkOutput("pc_wrap_w", pcW, 32'h00000000);

    // Reset while waiting for read data, then a late rvalid.
    pcInc = 1'b1;
    applyStimulus();
    pcInc = 1'b0;
    memRd = 1'b1;
    applyStimulus();
    memRd = 1'b0;
    memReady = 1'b1;
    applyStimulus();
    memReady = 1'b0;
    checkOutput("pre_rst_wait", {memReqN, memBusyN}, 2'b01);
    rst = 1'b1;
    applyStimulus();
    rst = 1'b0;
    checkOutput("rst_req_busy", {memReqN, memBusyN, mulBusyN}, 3'b000);
    checkOutput("rst_pc", pcN, 16'h0000);
    for (int i = 0; i < 8; i++) begin
      readRegs(i);
      checkOutput("rst_rf", rfDataN, 16'h0000);
    end
    readRegs(15);
    checkOutput("rst_rf15_w", rfDataW, 32'h00000000);
    memRvalid = 1'b1; memRdata = 16'h1234;
    applyStimulus();
    memRvalid = 1'b0;
    irLd = 1'b1;
    applyStimulus();
    irLd = 1'b0;
    checkOutput("late_rvalid", irN, 16'h0000);
    checkOutput("late_busy", memBusyN, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
